// File: rtl/result_select_stage.sv
// Registered writeback result select: NUM_SRC-way mux into a one-cycle stage with a one-entry skid buffer.
// Optional sticky out-of-range select flag sel_err, enabled by defining RESULT_SEL_ERR_EN.
module result_select_stage #(
  parameter  int WIDTH   = 32,
  parameter  int NUM_SRC = 3,
  parameter  int RD_W    = 5,
  localparam int SEL_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SRC*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic [RD_W-1:0]          in_rd,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  output logic [WIDTH-1:0]         out_data,
  output logic [RD_W-1:0]          out_rd,
  output logic                     out_valid,
`ifdef RESULT_SEL_ERR_EN
  output logic                     sel_err,
`endif
  input  logic                     out_ready
);

  // state   | meaning
  // S_EMPTY | main and skid both empty
  // S_ONE   | main holds the output entry, skid empty
  // S_FULL  | main holds the output entry, skid holds the next one
  // Encoding is {main_valid, skid_valid}.
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b10,
    S_FULL  = 2'b11
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main_data;
  logic [RD_W-1:0]  r_main_rd;
  logic [WIDTH-1:0] r_skid_data;
  logic [RD_W-1:0]  r_skid_rd;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_accept;
  logic             w_xfer;
  logic             w_load_main_in;
  logic             w_load_main_skid;
  logic             w_load_skid;

  // Unmatched select values fall through to zero, never X.
  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (in_sel == SEL_W'(k)) w_sel_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  assign in_ready  = ~r_state[0];
  assign out_valid = r_state[1];
  assign out_data  = r_main_data;
  assign out_rd    = r_main_rd;
  assign w_accept  = in_valid && in_ready;
  assign w_xfer    = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_state_nxt    = S_ONE;
            w_load_main_in = 1'b1;
          end
        end
        S_ONE: begin
          if (w_accept && w_xfer) begin
            w_load_main_in = 1'b1;
          end else if (w_accept) begin
            w_state_nxt = S_FULL;
            w_load_skid = 1'b1;
          end else if (w_xfer) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_xfer) begin
            w_state_nxt      = S_ONE;
            w_load_main_skid = 1'b1;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_data <= '0;
      r_main_rd   <= '0;
      r_skid_data <= '0;
      r_skid_rd   <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main_data <= w_sel_data;
        r_main_rd   <= in_rd;
      end else if (w_load_main_skid) begin
        r_main_data <= r_skid_data;
        r_main_rd   <= r_skid_rd;
      end
      if (w_load_skid) begin
        r_skid_data <= w_sel_data;
        r_skid_rd   <= in_rd;
      end
    end
  end

`ifdef RESULT_SEL_ERR_EN
  logic w_sel_oob;
  logic r_sel_err;

  assign w_sel_oob = (int'(in_sel) >= NUM_SRC);
  assign sel_err   = r_sel_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_sel_err <= 1'b0;
    else if (flush)                   r_sel_err <= 1'b0;
    else if (w_accept && w_sel_oob)   r_sel_err <= 1'b1;
  end
`endif

endmodule
